byte_mem_ctrl: RTL and testbench

- Parametrised, byte-addressed scratch memory for the node/sink routing tables: flags, knownSinks, neighborID, qValue and similar.
- Successor to the fixed 1024x8 single-port memory with 16-bit words. Adds configurable depth and word size, byte enables, a valid/ready request handshake, a registered read with error reporting, and a hardware clear-on-reset sequencer.
- Sits between the routing FSMs and storage. Word packing stays big-endian: the lowest address is the most significant byte.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/byte_mem_array.sv | 46 ++++
 rtl/byte_mem_ctrl.sv | 112 +++++++++++
 tb/tb_byte_mem_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the routing-table scratch memory: table base
// addresses and the controller state encoding.
package mem_pkg;

  localparam logic [15:0] FLAGS_BASE         = 16'h0000;
  localparam logic [15:0] KNOWN_SINKS_BASE   = 16'h0008;
  localparam logic [15:0] WORST_HOPS_BASE    = 16'h0028;
  localparam logic [15:0] NEIGHBOR_ID_BASE   = 16'h0048;
  localparam logic [15:0] CLUSTER_ID_BASE    = 16'h00C8;
  localparam logic [15:0] BATTERY_STAT_BASE  = 16'h0148;
  localparam logic [15:0] QVALUE_BASE        = 16'h01C8;
  localparam logic [15:0] SINK_IDS_BASE      = 16'h0248;
  localparam logic [15:0] NEXT_SINKS_BASE    = 16'h0700;
  localparam logic [15:0] BETTER_QVALUE_BASE = 16'h0710;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

endpackage

// File: rtl/byte_mem_array.sv
// DEPTH x 8 byte storage: one write lane per byte of the access word and a
// combinational big-endian multi-byte read, both starting at i_addr.
module byte_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 16,
  parameter int unsigned WB    = 2
) (
  input  logic            clk,
  input  logic [AW-1:0]   i_addr,
  input  logic [WB-1:0]   i_we,
  input  logic [8*WB-1:0] i_wdata,
  output logic [8*WB-1:0] o_rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   w_pos [WB];
  logic [WB-1:0] w_in_range;

  // Lane k addresses byte i_addr+k; lanes past the end are never touched.
  always_comb begin
    for (int unsigned k = 0; k < WB; k++) begin
      w_pos[k]      = {1'b0, i_addr} + (AW+1)'(k);
      w_in_range[k] = w_pos[k] < (AW+1)'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < WB; k++) begin
      if (i_we[WB-1-k] && w_in_range[k]) begin
        r_mem[w_pos[k][IW-1:0]] <= i_wdata[8*(WB-k)-1 -: 8];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < WB; k++) begin
      if (w_in_range[k]) begin
        o_rdata[8*(WB-k)-1 -: 8] = r_mem[w_pos[k][IW-1:0]];
      end
    end
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed scratch memory controller: optional clear-after-reset
// sequencer, valid/ready request port, range check and registered response.
module byte_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned WORD_BYTES     = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    nrst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  input  logic [WORD_BYTES-1:0]   req_be,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_busy
);

  localparam int unsigned CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cnt;
  logic                    w_accept;
  logic                    w_err;
  logic [WORD_BYTES-1:0]   w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [8*WORD_BYTES-1:0] w_wdata;
  logic [8*WORD_BYTES-1:0] w_rdata;
  logic                    r_rsp_valid;
  logic [8*WORD_BYTES-1:0] r_rsp_rdata;
  logic                    r_rsp_err;

  assign w_err = ({1'b0, req_addr} + AW1'(WORD_BYTES)) > AW1'(DEPTH);

  // During INIT the most significant lane is borrowed to zero byte[r_cnt].
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_we         = '0;
    w_addr       = req_addr;
    w_wdata      = req_wdata;
    case (r_state)
      ST_INIT: begin
        w_addr               = ADDR_WIDTH'(r_cnt);
        w_wdata              = '0;
        w_we[WORD_BYTES-1]   = 1'b1;
        if (r_cnt == CW'(DEPTH - 1)) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_accept = req_valid;
        if (req_valid && req_wr && !w_err) begin
          w_we = req_be;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (!req_wr && !w_err) ? w_rdata : '0;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  byte_mem_array #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH),
    .WB    (WORD_BYTES)
  ) u_array (
    .clk     (clock),
    .i_addr  (w_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign req_ready = (r_state == ST_READY);
  assign init_busy = (r_state == ST_INIT);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Bench for byte_mem_ctrl: clear-on-reset timing, table-driven accesses with a
// response scoreboard, back-to-back traffic, mid-clear reset, no-clear variant.
module tb_byte_mem_ctrl;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 16;
  localparam int unsigned WB    = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic          nrst, req_valid, req_ready, req_wr, rsp_valid, rsp_err, init_busy;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata, rsp_rdata;
  logic [1:0]    req_be;

  logic          nrst2, req_valid2, req_ready2, req_wr2, rsp_valid2, rsp_err2, init_busy2;
  logic [AW-1:0] req_addr2;
  logic [15:0]   req_wdata2, rsp_rdata2;
  logic [1:0]    req_be2;

  byte_mem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WORD_BYTES(WB), .CLEAR_ON_RESET(1)) dut (
    .clock(clock), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_busy(init_busy)
  );

  byte_mem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WORD_BYTES(WB), .CLEAR_ON_RESET(0)) dut2 (
    .clock(clock), .nrst(nrst2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_wr(req_wr2), .req_addr(req_addr2), .req_wdata(req_wdata2), .req_be(req_be2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .init_busy(init_busy2)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_latency", cyc, e.cyc);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'd1);
      end
    end
  endtask

  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input logic [15:0] exp_rdata, input logic exp_err);
    int waited = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!req_ready && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      sb.push_back('{exp_rdata, exp_err, cyc + 1});
      @(posedge clock);
      #1;
      req_valid = 1'b0;
    end
  endtask

  // Holds nrst low for ncyc rising edges, checks reset outputs, releases at a negedge.
  task automatic do_reset(input int ncyc);
    @(negedge clock);
    nrst = 1'b0;
    repeat (ncyc) @(negedge clock);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    nrst = 1'b1;
  endtask

  task automatic count_busy(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (init_busy && n < 3000) begin
      if (req_ready) bad++;
      n++;
      @(negedge clock);
    end
  endtask

  vec_t vt[16];
  int   nb, nbad;

  initial begin
    vt[0]  = '{1'b1, 16'h0009, 16'hA55A, 2'b11, 16'h0000, 1'b0};
    vt[1]  = '{1'b0, 16'h0009, 16'h0000, 2'b00, 16'hA55A, 1'b0};
    vt[2]  = '{1'b0, 16'h0008, 16'h0000, 2'b00, 16'h00A5, 1'b0};
    vt[3]  = '{1'b0, 16'h000A, 16'h0000, 2'b11, 16'h5A00, 1'b0};
    vt[4]  = '{1'b1, 16'h0100, 16'h1234, 2'b11, 16'h0000, 1'b0};
    vt[5]  = '{1'b1, 16'h0100, 16'hFFFF, 2'b01, 16'h0000, 1'b0};
    vt[6]  = '{1'b0, 16'h0100, 16'h0000, 2'b00, 16'h12FF, 1'b0};
    vt[7]  = '{1'b1, 16'h03FF, 16'hBEEF, 2'b11, 16'h0000, 1'b1};
    vt[8]  = '{1'b0, 16'h03FE, 16'h0000, 2'b00, 16'h0000, 1'b0};
    vt[9]  = '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1};
    vt[10] = '{1'b0, 16'h0030, 16'h0000, 2'b00, 16'h0000, 1'b0};
    vt[11] = '{1'b1, 16'h03FE, 16'h1357, 2'b10, 16'h0000, 1'b0};
    vt[12] = '{1'b0, 16'h03FE, 16'h0000, 2'b00, 16'h1300, 1'b0};
    vt[13] = '{1'b0, 16'h03FD, 16'h0000, 2'b00, 16'h0013, 1'b0};
    vt[14] = '{1'b1, 16'h0200, 16'hABCD, 2'b00, 16'h0000, 1'b0};
    vt[15] = '{1'b0, 16'h0200, 16'h0000, 2'b00, 16'h0000, 1'b0};

    nrst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    nrst2 = 1'b0; req_valid2 = 1'b0; req_wr2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; req_be2 = '0;

    fork
      monitor();
    join_none

    // No-clear variant: ready straight out of reset, memory usable at once.
    repeat (2) @(negedge clock);
    chk("nc_rst_ready", 32'(req_ready2), 32'd1);
    chk("nc_rst_busy", 32'(init_busy2), 32'd0);
    chk("nc_rst_rsp_valid", 32'(rsp_valid2), 32'd0);
    nrst2 = 1'b1;
    req_valid2 = 1'b1; req_wr2 = 1'b1; req_addr2 = 16'h0010; req_wdata2 = 16'hCAFE; req_be2 = 2'b11;
    @(negedge clock);
    chk("nc_wr_rsp_valid", 32'(rsp_valid2), 32'd1);
    chk("nc_wr_rsp_rdata", 32'(rsp_rdata2), 32'd0);
    req_wr2 = 1'b0;
    @(negedge clock);
    req_valid2 = 1'b0;
    chk("nc_rd_rsp_valid", 32'(rsp_valid2), 32'd1);
    chk("nc_rd_rsp_rdata", 32'(rsp_rdata2), 32'hCAFE);
    chk("nc_rd_rsp_err", 32'(rsp_err2), 32'd0);
    @(negedge clock);
    chk("nc_pulse_width", 32'(rsp_valid2), 32'd0);

    // Clear sequence; a write request offered during INIT must be ignored.
    do_reset(2);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'hFFFF; req_be = 2'b11;
    count_busy(nb, nbad);
    req_valid = 1'b0;
    chk("init_cycles", nb, 1024);
    chk("init_ready_low", nbad, 0);

    do_req(1'b0, KNOWN_SINKS_BASE, 16'h0000, 2'b11, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].rdata, vt[i].err);
    end

    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, KNOWN_SINKS_BASE + 16'(2*i), 16'(15 - i), 2'b11, 16'h0000, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, KNOWN_SINKS_BASE + 16'(2*i), 16'h0000, 2'b00, 16'(15 - i), 1'b0);
    end

    // Reset restarted at INIT cycle 500 must clear a previously written word.
    do_req(1'b1, 16'h0040, 16'h1234, 2'b11, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0040, 16'h0000, 2'b00, 16'h1234, 1'b0);
    repeat (3) @(negedge clock);
    do_reset(2);
    repeat (500) @(negedge clock);
    chk("mid_init_busy", 32'(init_busy), 32'd1);
    do_reset(1);
    count_busy(nb, nbad);
    chk("reinit_cycles", nb, 1024);
    chk("reinit_ready_low", nbad, 0);
    do_req(1'b0, 16'h0040, 16'h0000, 2'b00, 16'h0000, 1'b0);

    repeat (4) @(negedge clock);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
